// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage RISC-V core, driven by the
// hazard unit's stall/flush requests, plus saturating stall/flush event counters.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 12,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,

    // Hazard-unit requests. They are levels sampled on each rising edge and
    // take effect on that edge; there is no valid/ready handshake. Per stage:
    // rst beats flush, flush beats stall, stall beats load.
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,

    // Fetch side
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    output logic [31:0]       PCF,

    // Decode side
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,

    // Execute side
    output logic [CTRL_W-1:0] ctrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              validE,

    // Performance counters
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic flush_event;
    logic stall_inc;
    logic flush_inc;

    assign flush_event = flushD | flushE;
    assign stall_inc   = stallF && (stallCnt != CNT_MAX);
    assign flush_inc   = flush_event && (flushCnt != CNT_MAX);

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else if (!stallF) begin
            PCF <= PCNextF;
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            validD   <= 1'b1;
        end
    end

    // ID/EX register. A bubble zeroes RdE so the slot can never forward or write back;
    // under load-use (stallD & flushE) the held ID instruction re-enters EX next cycle.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            ctrlE    <= '0;
            RD1E     <= 32'h0;
            RD2E     <= 32'h0;
            ImmExtE  <= 32'h0;
            PCE      <= 32'h0;
            PCPlus4E <= 32'h0;
            Rs1E     <= 5'd0;
            Rs2E     <= 5'd0;
            RdE      <= 5'd0;
            validE   <= 1'b0;
        end else begin
            ctrlE    <= ctrlD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
            validE   <= validD;
        end
    end

    // Event counters count raw request cycles (not gated by valid) and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_inc) begin
                stallCnt <= stallCnt + CNT_ONE;
            end
            if (flush_inc) begin
                flushCnt <= flushCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed vector table, hand-written counter saturation
// and reset-during-stall sequences, then random stimulus against a stage-level model.
module tb_pipe_stage_regs;

    localparam int CTRL_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, stallF, stallD, flushD, flushE;
    logic [31:0]       PCNextF, InstrF, PCPlus4F;
    logic [CTRL_W-1:0] ctrlD;
    logic [31:0]       RD1D, RD2D, ImmExtD;
    logic [4:0]        Rs1D, Rs2D, RdD;

    logic [31:0]       PCF, InstrD, PCD, PCPlus4D;
    logic              validD, validE;
    logic [CTRL_W-1:0] ctrlE;
    logic [31:0]       RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]        Rs1E, Rs2E, RdE;
    logic [15:0]       stallCnt, flushCnt;

    // Second instance with 4-bit counters for saturation checks
    logic [31:0]       b_PCF, b_InstrD, b_PCD, b_PCPlus4D;
    logic              b_validD, b_validE;
    logic [CTRL_W-1:0] b_ctrlE;
    logic [31:0]       b_RD1E, b_RD2E, b_ImmExtE, b_PCE, b_PCPlus4E;
    logic [4:0]        b_Rs1E, b_Rs2E, b_RdE;
    logic [3:0]        b_stallCnt, b_flushCnt;

    pipe_stage_regs #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD),
        .ctrlD(ctrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ctrlE(ctrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .validE(validE),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    pipe_stage_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .PCF(b_PCF),
        .InstrD(b_InstrD), .PCD(b_PCD), .PCPlus4D(b_PCPlus4D), .validD(b_validD),
        .ctrlD(ctrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ctrlE(b_ctrlE), .RD1E(b_RD1E), .RD2E(b_RD2E), .ImmExtE(b_ImmExtE), .PCE(b_PCE),
        .PCPlus4E(b_PCPlus4E), .Rs1E(b_Rs1E), .Rs2E(b_Rs2E), .RdE(b_RdE), .validE(b_validE),
        .stallCnt(b_stallCnt), .flushCnt(b_flushCnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ctl(input logic r, input logic sf, input logic sd, input logic fd, input logic fe);
        rst = r; stallF = sf; stallD = sd; flushD = fd; flushE = fe;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, sf, sd, fd, fe;
        logic [31:0] pcn, instr;
        logic [4:0]  rd;
        logic [31:0] e_pcf, e_instrd, e_pcd;
        logic        e_vd;
        logic [4:0]  e_rde;
        logic        e_ve;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t vecs[11];

    // ---------------- stage-level reference model ----------------
    typedef struct {
        logic [31:0] instr, pc, pc4;
        logic        valid;
    } id_s;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       rd1, rd2, imm, pc, pc4;
        logic [4:0]        rs1, rs2, rd;
        logic              valid;
    } ex_s;

    logic [31:0] m_pc;
    id_s         m_id;
    ex_s         m_ex;
    int          m_stalls, m_flushes;

    function automatic id_s id_bubble();
        id_s b;
        b.instr = 32'h13; b.pc = 32'h0; b.pc4 = 32'h0; b.valid = 1'b0;
        return b;
    endfunction

    function automatic ex_s ex_bubble();
        ex_s b;
        b.ctrl = '0; b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.pc = 0; b.pc4 = 0;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.valid = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_id = id_bubble(); m_ex = ex_bubble();
        m_stalls = 0; m_flushes = 0;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        id_s n_id;
        ex_s n_ex;
        if (rst) begin
            model_reset();
            return;
        end
        if (flushE) n_ex = ex_bubble();
        else begin
            n_ex.ctrl = ctrlD; n_ex.rd1 = RD1D; n_ex.rd2 = RD2D; n_ex.imm = ImmExtD;
            n_ex.pc = m_id.pc; n_ex.pc4 = m_id.pc4;
            n_ex.rs1 = Rs1D; n_ex.rs2 = Rs2D; n_ex.rd = RdD; n_ex.valid = m_id.valid;
        end
        if (flushD)      n_id = id_bubble();
        else if (stallD) n_id = m_id;
        else begin
            n_id.instr = InstrF; n_id.pc = m_pc; n_id.pc4 = PCPlus4F; n_id.valid = 1'b1;
        end
        if (!stallF) m_pc = PCNextF;
        if (stallF) m_stalls++;
        if (flushD || flushE) m_flushes++;
        m_id = n_id;
        m_ex = n_ex;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic compare_model();
        check("PCF", PCF, m_pc);
        check("InstrD", InstrD, m_id.instr);
        check("PCD", PCD, m_id.pc);
        check("PCPlus4D", PCPlus4D, m_id.pc4);
        check("validD", validD, m_id.valid);
        check("ctrlE", ctrlE, m_ex.ctrl);
        check("RD1E", RD1E, m_ex.rd1);
        check("RD2E", RD2E, m_ex.rd2);
        check("ImmExtE", ImmExtE, m_ex.imm);
        check("PCE", PCE, m_ex.pc);
        check("PCPlus4E", PCPlus4E, m_ex.pc4);
        check("Rs1E", Rs1E, m_ex.rs1);
        check("Rs2E", Rs2E, m_ex.rs2);
        check("RdE", RdE, m_ex.rd);
        check("validE", validE, m_ex.valid);
        check("stallCnt", stallCnt, sat(m_stalls, 65535));
        check("flushCnt", flushCnt, sat(m_flushes, 65535));
        check("stallCnt4", b_stallCnt, sat(m_stalls, 15));
        check("flushCnt4", b_flushCnt, sat(m_flushes, 15));
    endtask

    initial begin
        drive_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        PCNextF = 0; InstrF = 0; PCPlus4F = 0; ctrlD = '0;
        RD1D = 0; RD2D = 0; ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;

        //          rst   sF    sD    fD    fE    PCNextF       InstrF        Rd     PCF           InstrD        PCD           vD    RdE    vE    sCnt    fCnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,       32'h0,        5'd0,  32'h0,        32'h13,       32'h0,        1'b0, 5'd0,  1'b0, 16'd0,  16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,       32'h0,        5'd0,  32'h0,        32'h13,       32'h0,        1'b0, 5'd0,  1'b0, 16'd0,  16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4,        32'h00500093, 5'd0,  32'h4,        32'h00500093, 32'h0,        1'b1, 5'd0,  1'b0, 16'd0,  16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,        32'h00a00113, 5'd1,  32'h8,        32'h00a00113, 32'h4,        1'b1, 5'd1,  1'b1, 16'd0,  16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hc,        32'h11111111, 5'd5,  32'h8,        32'h00a00113, 32'h4,        1'b1, 5'd0,  1'b0, 16'd1,  16'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hc,        32'h00300193, 5'd5,  32'hc,        32'h00300193, 32'h8,        1'b1, 5'd5,  1'b1, 16'd1,  16'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10,       32'hdeadbeef, 5'd7,  32'h10,       32'h13,       32'h0,        1'b0, 5'd0,  1'b0, 16'd1,  16'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14,       32'h00400213, 5'd2,  32'h14,       32'h00400213, 32'h10,       1'b1, 5'd2,  1'b0, 16'd1,  16'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h18,       32'h22222222, 5'd3,  32'h14,       32'h00400213, 32'h10,       1'b1, 5'd3,  1'b1, 16'd2,  16'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1c,       32'h33333333, 5'd6,  32'h0,        32'h13,       32'h0,        1'b0, 5'd0,  1'b0, 16'd0,  16'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       32'h00100093, 5'd4,  32'h20,       32'h00100093, 32'h0,        1'b1, 5'd4,  1'b0, 16'd0,  16'd0};

        for (int i = 0; i < 11; i++) begin
            drive_ctl(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe);
            PCNextF = vecs[i].pcn; InstrF = vecs[i].instr; PCPlus4F = vecs[i].pcn;
            RdD = vecs[i].rd; ctrlD = {7'b0, vecs[i].rd};
            tick();
            check($sformatf("vec%0d PCF", i), PCF, vecs[i].e_pcf);
            check($sformatf("vec%0d InstrD", i), InstrD, vecs[i].e_instrd);
            check($sformatf("vec%0d PCD", i), PCD, vecs[i].e_pcd);
            check($sformatf("vec%0d validD", i), validD, vecs[i].e_vd);
            check($sformatf("vec%0d RdE", i), RdE, vecs[i].e_rde);
            check($sformatf("vec%0d ctrlE", i), ctrlE, {7'b0, vecs[i].e_rde});
            check($sformatf("vec%0d validE", i), validE, vecs[i].e_ve);
            check($sformatf("vec%0d stallCnt", i), stallCnt, vecs[i].e_sc);
            check($sformatf("vec%0d flushCnt", i), flushCnt, vecs[i].e_fc);
        end

        // Counter saturation: 20 stall cycles on the 4-bit instance
        drive_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        PCNextF = 32'h100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat stallCnt4 c%0d", i), b_stallCnt, (i > 15) ? 15 : i);
            check($sformatf("sat stallCnt c%0d", i), stallCnt, i);
            check($sformatf("sat PCF c%0d", i), PCF, 32'h0);
        end
        check("sat final", b_stallCnt, 4'hF);

        // Reset asserted in the middle of a stall/flush sequence
        drive_ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("midrst PCF", PCF, 32'h0);
        check("midrst InstrD", InstrD, 32'h13);
        check("midrst validD", validD, 1'b0);
        check("midrst validE", validE, 1'b0);
        check("midrst stallCnt", stallCnt, 16'd0);
        check("midrst flushCnt", flushCnt, 16'd0);
        check("midrst stallCnt4", b_stallCnt, 4'd0);

        // Randomized run against the stage-level model
        drive_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            stallF = ($urandom_range(0, 2) == 0);
            stallD = ($urandom_range(0, 2) == 0);
            flushD = ($urandom_range(0, 4) == 0);
            flushE = ($urandom_range(0, 4) == 0);
            PCNextF  = $urandom; InstrF = $urandom; PCPlus4F = $urandom;
            ctrlD    = CTRL_W'($urandom);
            RD1D     = $urandom; RD2D = $urandom; ImmExtD = $urandom;
            Rs1D     = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
            model_step();
            tick();
            compare_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
